// File: rtl/processor_core.sv
// processor_core: single-cycle 16-bit processor with internal ROM,
// 8x16 register file (r0 hardwired to zero) and a combinational ALU.
// One instruction commits per rising clk edge; reset is async active-low.

module processor_core_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  raddr1,
    input  logic [2:0]  raddr2,
    output logic [15:0] rdata1,
    output logic [15:0] rdata2
);
    logic [15:0] reg_file   [0:7];
    logic [15:0] reg_file_d [0:7];

    // Next register state: one write per cycle, writes to r0 dropped
    always_comb begin
        reg_file_d = reg_file;
        if (we && (waddr != 3'd0)) begin
            reg_file_d[waddr] = wdata;
        end
    end

    // Register storage, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) reg_file[i] <= 16'h0000;
        end else begin
            reg_file <= reg_file_d;
        end
    end

    // Combinational reads; r0 always reads as zero
    always_comb begin
        rdata1 = (raddr1 == 3'd0) ? 16'h0000 : reg_file[raddr1];
        rdata2 = (raddr2 == 3'd0) ? 16'h0000 : reg_file[raddr2];
    end
endmodule

module processor_core (
    input  logic clk,
    input  logic reset
);
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LI   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    logic [7:0]  pc_q, pc_d, pc;
    logic [15:0] instruction;
    logic [3:0]  opcode;
    logic [2:0]  read_addr1, read_addr2, write_addr;
    logic [15:0] read_data1, read_data2, alu_result;
    logic        write_enable, branch_enable;
    logic [7:0]  branch_address;
    logic [15:0] imm6_sext, imm9_zext;

    assign pc = pc_q;

    // Program ROM, read combinationally at the current pc
    always_comb begin
        case (pc)
            8'd0:    instruction = 16'h7205; // LI  r1,5
            8'd1:    instruction = 16'h7403; // LI  r2,3
            8'd2:    instruction = 16'h1650; // ADD r3,r1,r2
            8'd3:    instruction = 16'h2850; // SUB r4,r1,r2
            8'd4:    instruction = 16'h8241; // BEQ r1,r1,+1
            8'd5:    instruction = 16'h7A63; // LI  r5,99
            8'd6:    instruction = 16'h3C50; // AND r6,r1,r2
            8'd7:    instruction = 16'hF000; // HALT
            default: instruction = 16'h0000; // NOP
        endcase
    end

    // Field decode and operand routing; BEQ compares [11:9] against [8:6]
    always_comb begin
        opcode     = instruction[15:12];
        write_addr = instruction[11:9];
        imm6_sext  = {{10{instruction[5]}}, instruction[5:0]};
        imm9_zext  = {7'd0, instruction[8:0]};
        if (opcode == OP_BEQ) begin
            read_addr1 = instruction[11:9];
            read_addr2 = instruction[8:6];
        end else begin
            read_addr1 = instruction[8:6];
            read_addr2 = instruction[5:3];
        end
        write_enable   = (opcode >= OP_ADD) && (opcode <= OP_LI);
        branch_address = pc + 8'd1 + imm6_sext[7:0];
        branch_enable  = (opcode == OP_BEQ) && (read_data1 == read_data2);
    end

    processor_core_regfile regfile (
        .clk    (clk),
        .rst_n  (reset),
        .we     (write_enable),
        .waddr  (write_addr),
        .wdata  (alu_result),
        .raddr1 (read_addr1),
        .raddr2 (read_addr2),
        .rdata1 (read_data1),
        .rdata2 (read_data2)
    );

    // ALU: all arithmetic wraps at 16 bits, no flags
    always_comb begin
        alu_result = 16'h0000;
        case (opcode)
            OP_ADD:  alu_result = read_data1 + read_data2;
            OP_SUB:  alu_result = read_data1 - read_data2;
            OP_AND:  alu_result = read_data1 & read_data2;
            OP_OR:   alu_result = read_data1 | read_data2;
            OP_XOR:  alu_result = read_data1 ^ read_data2;
            OP_ADDI: alu_result = read_data1 + imm6_sext;
            OP_LI:   alu_result = imm9_zext;
            default: alu_result = 16'h0000;
        endcase
    end

    // Next pc: HALT holds, taken branch jumps, otherwise increment (wraps)
    always_comb begin
        pc_d = pc_q + 8'd1;
        if (opcode == OP_HALT) begin
            pc_d = pc_q;
        end else if (branch_enable) begin
            pc_d = branch_address;
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 8'd0;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core: reset, default program, branch,
// HALT, async reset mid-run, and forced-instruction corner cases.

module tb_processor_core;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    processor_core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (dut.pc !== 8'd0) begin
            errors++; $display("FAIL reset_pc got %0d exp 0", dut.pc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.regfile.reg_file[i] !== 16'h0000) begin
                errors++; $display("FAIL reset_r%0d got %h exp 0000", i, dut.regfile.reg_file[i]);
            end
        end
        checks++;
        if (dut.instruction !== 16'h7205) begin
            errors++; $display("FAIL reset_instr got %h exp 7205", dut.instruction);
        end
    endtask

    task automatic check_final(input string tag);
        logic [15:0] exp [0:7];
        exp = '{16'd0, 16'd5, 16'd3, 16'd8, 16'd2, 16'd0, 16'd1, 16'd0};
        checks++;
        if (dut.pc !== 8'd7) begin
            errors++; $display("FAIL %s_pc got %0d exp 7", tag, dut.pc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.regfile.reg_file[i] !== exp[i]) begin
                errors++; $display("FAIL %s_r%0d got %h exp %h", tag, i, dut.regfile.reg_file[i], exp[i]);
            end
        end
    endtask

    task automatic test_default_program();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step();
        checks++;
        if (dut.pc !== 8'd4) begin
            errors++; $display("FAIL prog_pc4 got %0d exp 4", dut.pc);
        end
        checks++;
        if (dut.branch_enable !== 1'b1) begin
            errors++; $display("FAIL beq_taken got %b exp 1", dut.branch_enable);
        end
        checks++;
        if (dut.branch_address !== 8'd6) begin
            errors++; $display("FAIL beq_addr got %0d exp 6", dut.branch_address);
        end
        step();
        checks++;
        if (dut.pc !== 8'd6) begin
            errors++; $display("FAIL beq_next_pc got %0d exp 6", dut.pc);
        end
        step();
        check_final("prog");
    endtask

    task automatic test_halt();
        repeat (5) step();
        check_final("halt");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (dut.pc !== 8'd3 || dut.regfile.reg_file[3] !== 16'd8) begin
            errors++; $display("FAIL mid_pre got pc %0d r3 %h exp pc 3 r3 0008", dut.pc, dut.regfile.reg_file[3]);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut.pc !== 8'd0) begin
            errors++; $display("FAIL async_pc got %0d exp 0", dut.pc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.regfile.reg_file[i] !== 16'h0000) begin
                errors++; $display("FAIL async_r%0d got %h exp 0000", i, dut.regfile.reg_file[i]);
            end
        end
        step();
        checks++;
        if (dut.pc !== 8'd0 || dut.regfile.reg_file[1] !== 16'h0000) begin
            errors++; $display("FAIL hold_in_reset got pc %0d r1 %h exp 0 0000", dut.pc, dut.regfile.reg_file[1]);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) step();
        check_final("rerun");
    endtask

    task automatic test_overrides();
        int budget;
        // LI r0,7 must not change r0
        force dut.instruction = 16'h7007;
        #1;
        checks++;
        if (dut.write_enable !== 1'b1 || dut.write_addr !== 3'd0) begin
            errors++; $display("FAIL li_r0_decode got we %b wa %0d exp 1 0", dut.write_enable, dut.write_addr);
        end
        step();
        checks++;
        if (dut.regfile.reg_file[0] !== 16'h0000 || dut.read_data1 !== 16'h0000) begin
            errors++; $display("FAIL r0_hardwired got %h exp 0000", dut.regfile.reg_file[0]);
        end
        // SUB r3,r2,r1 : 3 - 5 wraps
        force dut.instruction = 16'h2688;
        #1;
        checks++;
        if (dut.alu_result !== 16'hFFFE) begin
            errors++; $display("FAIL sub_wrap_alu got %h exp fffe", dut.alu_result);
        end
        step();
        checks++;
        if (dut.regfile.reg_file[3] !== 16'hFFFE) begin
            errors++; $display("FAIL sub_wrap_r3 got %h exp fffe", dut.regfile.reg_file[3]);
        end
        // ADDI r4,r1,-1
        force dut.instruction = 16'h687F;
        #1;
        checks++;
        if (dut.alu_result !== 16'h0004) begin
            errors++; $display("FAIL addi_neg_alu got %h exp 0004", dut.alu_result);
        end
        step();
        checks++;
        if (dut.regfile.reg_file[4] !== 16'h0004) begin
            errors++; $display("FAIL addi_neg_r4 got %h exp 0004", dut.regfile.reg_file[4]);
        end
        // BEQ r1,r2 not taken (5 != 3)
        force dut.instruction = 16'h8282;
        #1;
        checks++;
        if (dut.branch_enable !== 1'b0 || dut.write_enable !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken got be %b we %b exp 0 0", dut.branch_enable, dut.write_enable);
        end
        step();
        checks++;
        if (dut.pc !== 8'd11) begin
            errors++; $display("FAIL beq_fallthru_pc got %0d exp 11", dut.pc);
        end
        // BEQ r1,r1,-3 from pc 11 lands on 9
        force dut.instruction = 16'h827D;
        #1;
        checks++;
        if (dut.branch_address !== 8'd9) begin
            errors++; $display("FAIL beq_back_addr got %0d exp 9", dut.branch_address);
        end
        step();
        checks++;
        if (dut.pc !== 8'd9) begin
            errors++; $display("FAIL beq_back_pc got %0d exp 9", dut.pc);
        end
        // NOP run to pc 255, then wrap to 0
        force dut.instruction = 16'h0000;
        budget = 0;
        while (dut.pc !== 8'd255 && budget < 300) begin
            step();
            budget++;
        end
        checks++;
        if (dut.pc !== 8'd255 || budget != 246) begin
            errors++; $display("FAIL reach_255 got pc %0d after %0d edges exp 255 after 246", dut.pc, budget);
        end
        step();
        checks++;
        if (dut.pc !== 8'd0) begin
            errors++; $display("FAIL pc_wrap got %0d exp 0", dut.pc);
        end
        checks++;
        if (dut.regfile.reg_file[1] !== 16'd5 || dut.regfile.reg_file[4] !== 16'd4) begin
            errors++; $display("FAIL nop_no_write got r1 %h r4 %h exp 0005 0004", dut.regfile.reg_file[1], dut.regfile.reg_file[4]);
        end
        release dut.instruction;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        test_reset();
        test_default_program();
        test_halt();
        test_async_reset();
        test_overrides();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
